// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module : bcd_pkg
// Brief  : Shared 7-segment encoding constants and BCD-to-segment function.
// Rev    : 1.0  initial release
// ============================================================================
package bcd_pkg;

    // Active-low segments ordered {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        case (bcd)
            4'd0:    bcd_to_seg = SEG_0;
            4'd1:    bcd_to_seg = SEG_1;
            4'd2:    bcd_to_seg = SEG_2;
            4'd3:    bcd_to_seg = SEG_3;
            4'd4:    bcd_to_seg = SEG_4;
            4'd5:    bcd_to_seg = SEG_5;
            4'd6:    bcd_to_seg = SEG_6;
            4'd7:    bcd_to_seg = SEG_7;
            4'd8:    bcd_to_seg = SEG_8;
            4'd9:    bcd_to_seg = SEG_9;
            default: bcd_to_seg = SEG_DASH;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_display_scanner_if.sv
`default_nettype none
// ============================================================================
// Module : bcd_display_scanner_if
// Brief  : Digit load and multiplexed display bus of the BCD display scanner.
// Rev    : 1.0  initial release
// ============================================================================
interface bcd_display_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic                    load;
    logic [6:0]              seg_n;
    logic [NUM_DIGITS-1:0]   an_n;
    logic                    frame_done;

    modport master (
        output digits_in, load,
        input  seg_n, an_n, frame_done
    );

    modport slave (
        input  digits_in, load,
        output seg_n, an_n, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/bcd_to_7seg.sv
`default_nettype none
// ============================================================================
// Module : bcd_to_7seg
// Brief  : Combinational BCD to active-low 7-segment decoder; non-BCD -> dash.
// Rev    : 1.0  initial release
// ============================================================================
module bcd_to_7seg
    import bcd_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg_n
);
    assign o_seg_n = bcd_to_seg(i_bcd);
endmodule
`default_nettype wire

// File: rtl/bcd_display_scanner.sv
`default_nettype none
// ============================================================================
// Module : bcd_display_scanner
// Brief  : Multiplexed common-anode display driver with frame-aligned snapshot
//          and leading-zero blanking.
// Rev    : 1.0  initial release
// ============================================================================
module bcd_display_scanner
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int BLANK_CYC  = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    bcd_display_scanner_if.slave   bus
);
    localparam int c_tick_w = $clog2(SCAN_DIV);
    localparam int c_idx_w  = $clog2(NUM_DIGITS);

    logic [c_tick_w-1:0]         r_tick;
    logic [c_idx_w-1:0]          r_idx;
    logic [NUM_DIGITS-1:0][3:0]  r_disp;
    logic [NUM_DIGITS-1:0][3:0]  r_pending;
    logic                        r_pending_valid;
    logic [6:0]                  r_seg_n;
    logic [NUM_DIGITS-1:0]       r_an_n;
    logic                        r_frame_done;

    logic [NUM_DIGITS-1:0][3:0]  w_digits_in;
    logic                        w_slot_end;
    logic                        w_boundary;
    logic [NUM_DIGITS-1:0]       w_blank;
    logic                        w_lz_run;
    logic [3:0]                  w_sel_digit;
    logic [6:0]                  w_seg_enc;
    logic [NUM_DIGITS-1:0]       w_an_sel;

    assign w_digits_in = bus.digits_in;
    assign w_slot_end  = (r_tick == c_tick_w'(SCAN_DIV - 1));
    assign w_boundary  = w_slot_end && (r_idx == c_idx_w'(NUM_DIGITS - 1));
    assign w_sel_digit = r_disp[r_idx];
    assign w_an_sel    = ~(NUM_DIGITS'(1) << r_idx);

    // A digit is blanked while it and every more significant digit are zero
    always_comb begin
        w_blank  = '0;
        w_lz_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            w_lz_run   = w_lz_run && (r_disp[i] == 4'd0);
            w_blank[i] = w_lz_run;
        end
    end

    bcd_to_7seg u_dec (
        .i_bcd   (w_sel_digit),
        .o_seg_n (w_seg_enc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick          <= '0;
            r_idx           <= '0;
            r_disp          <= '0;
            r_pending       <= '0;
            r_pending_valid <= 1'b0;
            r_seg_n         <= SEG_OFF;
            r_an_n          <= '1;
            r_frame_done    <= 1'b0;
        end else begin
            r_tick <= w_slot_end ? '0 : r_tick + c_tick_w'(1);
            if (w_slot_end) begin
                r_idx <= (r_idx == c_idx_w'(NUM_DIGITS - 1)) ? '0 : r_idx + c_idx_w'(1);
            end

            r_an_n       <= (r_tick >= c_tick_w'(BLANK_CYC)) ? w_an_sel : '1;
            r_seg_n      <= w_blank[r_idx] ? SEG_OFF : w_seg_enc;
            r_frame_done <= w_boundary;

            // Display contents only change at a frame boundary
            if (w_boundary) begin
                if (bus.load) begin
                    r_disp <= w_digits_in;
                end else if (r_pending_valid) begin
                    r_disp <= r_pending;
                end
                r_pending_valid <= 1'b0;
            end else if (bus.load) begin
                r_pending       <= w_digits_in;
                r_pending_valid <= 1'b1;
            end
        end
    end

    assign bus.seg_n      = r_seg_n;
    assign bus.an_n       = r_an_n;
    assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_scanner.sv
`default_nettype none
// ============================================================================
// Module : tb_bcd_display_scanner
// Brief  : Scoreboard bench; reference model predicts every output cycle.
// Rev    : 1.0  initial release
// ============================================================================
module tb_bcd_display_scanner;
    localparam int N = 4;
    localparam int S = 4;
    localparam int B = 1;
    localparam int FRAME = N * S;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    bcd_display_scanner_if #(.NUM_DIGITS(N)) bus ();

    bcd_display_scanner #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (S),
        .BLANK_CYC  (B)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]   seg;
        logic [N-1:0] an;
        logic         fd;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model state: edges since reset release, shown and pending values
    int   n_edges;
    int   disp_m;
    int   pend_m;
    bit   pv_m;

    function automatic logic [6:0] enc_m(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit ld, input logic [15:0] din);
        exp_t e;
        int   phase, slot, digit;
        bit   bnd;
        bus.load      = ld;
        bus.digits_in = din;
        phase = n_edges % S;
        slot  = (n_edges / S) % N;
        digit = (disp_m >> (4 * slot)) & 15;
        bnd   = (phase == S - 1) && (slot == N - 1);
        e.an  = (phase >= B) ? ~(N'(1) << slot) : '1;
        e.seg = (slot > 0 && (disp_m >> (4 * slot)) == 0) ? 7'h7F : enc_m(digit);
        e.fd  = bnd;
        q.push_back(e);
        if (bnd) begin
            if (ld)        disp_m = int'(din);
            else if (pv_m) disp_m = pend_m;
            pv_m = 1'b0;
        end else if (ld) begin
            pend_m = int'(din);
            pv_m   = 1'b1;
        end
        n_edges++;
        @(posedge clk);
        #2;
        bus.load = 1'b0;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 16'h0);
    endtask

    task automatic load_on_boundary(input logic [15:0] din);
        while ((n_edges % FRAME) != FRAME - 1) step(1'b0, 16'h0);
        step(1'b1, din);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_seg_n"}, 32'(bus.seg_n), 32'h7F);
        check({tag, "_an_n"}, 32'(bus.an_n), 32'hF);
        check({tag, "_frame_done"}, 32'(bus.frame_done), 32'h0);
    endtask

    task automatic release_reset();
        reset_n = 1'b1;
        n_edges = 0;
        disp_m  = 0;
        pend_m  = 0;
        pv_m    = 1'b0;
    endtask

    // Monitor: every clock the DUT presents a new output set
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            check("seg_n", 32'(bus.seg_n), 32'(mon_e.seg));
            check("an_n", 32'(bus.an_n), 32'(mon_e.an));
            check("frame_done", 32'(bus.frame_done), 32'(mon_e.fd));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rnd;
        bus.load      = 1'b0;
        bus.digits_in = '0;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("reset_hold");
        release_reset();

        idle(2 * FRAME);
        step(1'b1, 16'h1234);
        idle(2 * FRAME);
        step(1'b1, 16'h0050);
        idle(2 * FRAME);
        step(1'b1, 16'h0500);
        idle(2 * FRAME);
        step(1'b1, 16'h00A0);
        idle(2 * FRAME);

        // Overwritten pending value must never reach the display
        idle(3);
        step(1'b1, 16'h1111);
        idle(2);
        step(1'b1, 16'h2222);
        idle(2 * FRAME);
        load_on_boundary(16'h9876);
        idle(2 * FRAME);
        load_on_boundary(16'h0000);
        idle(FRAME);

        // Async reset mid-slot with a pending load outstanding
        idle(5);
        step(1'b1, 16'h7777);
        idle(1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("reset_mid");
        release_reset();
        idle(2 * FRAME);

        for (int i = 0; i < 800; i++) begin
            rnd = 16'($urandom());
            for (int d = 0; d < N; d++)
                if ($urandom_range(0, 2) == 0) rnd[4*d +: 4] = 4'h0;
            if ($urandom_range(0, 3) == 0) rnd = rnd >> (4 * $urandom_range(1, 3));
            step($urandom_range(0, 7) == 0, rnd);
        end
        idle(FRAME);

        @(posedge clk);
        #3;
        check("queue_drained", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
